// File: rtl/act_buf_pkg.sv
// Shared defaults, bank index type and saturating add for the layer activation buffer.
package act_buf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 64;
    localparam int ADDR_W_DEF = 16;
    localparam int SAT_W      = 64;

    typedef logic bank_idx_t;

    // Operands arrive sign-extended to SAT_W; the result is clamped to a signed w-bit range.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W-1:0] s, hi, lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi)      return hi;
        else if (s < lo) return lo;
        else             return s;
    endfunction

endpackage

// File: rtl/act_buf_bank.sv
// One activation bank: single write port, single registered read port, contents never reset.
module act_buf_bank
    import act_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [AW-1:0]            waddr_i,
    input  logic signed [DATA_W-1:0] wdata_i,
    input  logic                     re_i,
    input  logic [AW-1:0]            raddr_i,
    output logic signed [DATA_W-1:0] rdata_o
);

    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic signed [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/layer_act_buffer.sv
// Ping-pong activation buffer between a layer producer and a layer consumer.
// Define ACT_BUF_ACC_EN to enable saturating accumulate writes qualified by wr_acc.
module layer_act_buffer
    import act_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     wr_acc,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     wr_commit,
    output logic                     wr_ready,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic                     rd_release,
    output logic                     rd_avail,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    output logic [1:0]               fill_level,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [1:0]               full_q, full_d;
    bank_idx_t                wr_bank_q, rd_bank_q, rd_sel_q;
    logic                     err_q, err_d;
    logic                     rd_valid_q, rd_oob_q;
    logic signed [DATA_W-1:0] rd_hold_q, rd_word;

    logic wr_oob, rd_oob, wr_ok, rd_ok, rd_mem, commit_ok, release_ok;

    logic                     mem_we, fetch;
    bank_idx_t                mem_wbank;
    logic [AW-1:0]            mem_waddr;
    logic signed [DATA_W-1:0] mem_wdata;
    logic signed [DATA_W-1:0] bank_rdata [2];

    assign wr_ready   = !full_q[wr_bank_q];
    assign rd_avail   = full_q[rd_bank_q];
    assign fill_level = 2'(full_q[0]) + 2'(full_q[1]);
    assign err        = err_q;
    assign rd_valid   = rd_valid_q;

    assign wr_oob     = wr_addr >= DEPTH_A;
    assign rd_oob     = rd_addr >= DEPTH_A;
    assign wr_ok      = wr_en && wr_ready && !wr_oob;
    assign rd_ok      = rd_en && rd_avail;
    assign rd_mem     = rd_ok && !rd_oob;
    assign commit_ok  = wr_commit && wr_ready;
    assign release_ok = rd_release && rd_avail;

    // Commit and release can only both succeed on different banks, so the two updates never collide.
    always_comb begin
        full_d = full_q;
        if (commit_ok)  full_d[wr_bank_q] = 1'b1;
        if (release_ok) full_d[rd_bank_q] = 1'b0;
        err_d = err_q
              | (wr_en && !wr_ok)
              | (rd_en && (!rd_avail || rd_oob))
              | (wr_commit && !wr_ready)
              | (rd_release && !rd_avail);
    end

`ifdef ACT_BUF_ACC_EN
    // Writes retire one edge late so the write bank's read port can fetch the old word; the
    // retiring word is forwarded to a same-address accumulate or consumer read on that edge.
    logic                     pend_q, pend_acc_q, acc_fwd_q, rd_fwd_q;
    bank_idx_t                pend_bank_q;
    logic [AW-1:0]            pend_addr_q;
    logic signed [DATA_W-1:0] pend_data_q, acc_fwd_data_q, rd_fwd_data_q, old_word, pend_word;
    logic signed [SAT_W-1:0]  sat_res;

    assign old_word  = acc_fwd_q ? acc_fwd_data_q : bank_rdata[pend_bank_q];
    assign sat_res   = sat_add(SAT_W'(old_word), SAT_W'(pend_data_q), DATA_W);
    assign pend_word = pend_acc_q ? sat_res[DATA_W-1:0] : pend_data_q;

    assign fetch     = wr_ok && wr_acc;
    assign mem_we    = pend_q;
    assign mem_wbank = pend_bank_q;
    assign mem_waddr = pend_addr_q;
    assign mem_wdata = pend_word;
    assign rd_word   = rd_fwd_q ? rd_fwd_data_q : bank_rdata[rd_sel_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            acc_fwd_q <= 1'b0;
            rd_fwd_q  <= 1'b0;
        end else begin
            pend_q    <= wr_ok;
            acc_fwd_q <= pend_q && wr_ok && (pend_bank_q == wr_bank_q)
                         && (pend_addr_q == wr_addr[AW-1:0]);
            rd_fwd_q  <= pend_q && rd_mem && (pend_bank_q == rd_bank_q)
                         && (pend_addr_q == rd_addr[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        pend_acc_q     <= wr_acc;
        pend_bank_q    <= wr_bank_q;
        pend_addr_q    <= wr_addr[AW-1:0];
        pend_data_q    <= wr_data;
        acc_fwd_data_q <= pend_word;
        rd_fwd_data_q  <= pend_word;
    end
`else
    logic unused_acc;
    assign unused_acc = wr_acc;

    assign fetch     = 1'b0;
    assign mem_we    = wr_ok;
    assign mem_wbank = wr_bank_q;
    assign mem_waddr = wr_addr[AW-1:0];
    assign mem_wdata = wr_data;
    assign rd_word   = bank_rdata[rd_sel_q];
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic rd_hit;
        assign rd_hit = rd_mem && (rd_bank_q == bank_idx_t'(b));

        act_buf_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk     (clk),
            .we_i    (mem_we && (mem_wbank == bank_idx_t'(b))),
            .waddr_i (mem_waddr),
            .wdata_i (mem_wdata),
            .re_i    (rd_hit || (fetch && (wr_bank_q == bank_idx_t'(b)))),
            .raddr_i (rd_hit ? rd_addr[AW-1:0] : wr_addr[AW-1:0]),
            .rdata_o (bank_rdata[b])
        );
    end

    // rd_data is muxed from registered state so reset clears it without waiting for an edge.
    assign rd_data = !rd_valid_q ? rd_hold_q : (rd_oob_q ? '0 : rd_word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_sel_q   <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_q ^ commit_ok;
            rd_bank_q  <= rd_bank_q ^ release_ok;
            rd_sel_q   <= rd_bank_q;
            err_q      <= err_d;
            rd_valid_q <= rd_ok;
            rd_oob_q   <= rd_oob;
            rd_hold_q  <= rd_data;
        end
    end

endmodule

// File: tb/tb_layer_act_buffer.sv
// Self-checking bench for layer_act_buffer: directed scenarios plus a random phase against a bank model.
module tb_layer_act_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
`ifdef ACT_BUF_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic                 clk, rst_n;
    logic                 wr_en, wr_acc, wr_commit, rd_en, rd_release;
    logic [15:0]          wr_addr, rd_addr;
    logic signed [DW-1:0] wr_data;
    logic                 wr_ready, rd_avail, rd_valid, err;
    logic signed [DW-1:0] rd_data;
    logic [1:0]           fill_level;

    layer_act_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_acc(wr_acc), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release), .rd_avail(rd_avail),
        .rd_data(rd_data), .rd_valid(rd_valid), .fill_level(fill_level), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: two word arrays, full flags, bank pointers, sticky error, expected read result.
    logic signed [DW-1:0] mem_m [2][DEPTH];
    bit                   full_m [2];
    int                   wb_m, rb_m;
    bit                   err_m, vld_m;
    logic signed [DW-1:0] data_m;
    int                   total, bad;

    function automatic logic signed [DW-1:0] sat32(logic signed [DW-1:0] a, logic signed [DW-1:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s > SMAX) return 32'sh7fffffff;
        if (s < SMIN) return 32'sh80000000;
        return s[DW-1:0];
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("wr_ready", 64'(wr_ready), 64'(!full_m[wb_m]));
        chk("rd_avail", 64'(rd_avail), 64'(full_m[rb_m]));
        chk("fill_level", 64'(fill_level), 64'(int'(full_m[0]) + int'(full_m[1])));
        chk("err", 64'(err), 64'(err_m));
        chk("rd_valid", 64'(rd_valid), 64'(vld_m));
        chk("rd_data", rd_data, data_m);
    endtask

    task automatic idle();
        wr_en = 0; wr_acc = 0; wr_addr = 0; wr_data = 0; wr_commit = 0;
        rd_en = 0; rd_addr = 0; rd_release = 0;
    endtask

    // One clock cycle: drive, apply the rules to the model on the edge, check #1 later.
    task automatic cyc(bit we, int wa, logic signed [DW-1:0] wd, bit acc, bit wc, bit re, int ra, bit rr);
        bit wrdy, ravl;
        wr_en = we; wr_addr = wa[15:0]; wr_data = wd; wr_acc = acc; wr_commit = wc;
        rd_en = re; rd_addr = ra[15:0]; rd_release = rr;
        @(posedge clk);
        wrdy  = !full_m[wb_m];
        ravl  = full_m[rb_m];
        vld_m = 0;
        if (re) begin
            if (!ravl) err_m = 1;
            else begin
                vld_m = 1;
                if (ra >= DEPTH) begin data_m = 0; err_m = 1; end
                else data_m = mem_m[rb_m][ra];
            end
        end
        if (we) begin
            if (!wrdy || wa >= DEPTH) err_m = 1;
            else mem_m[wb_m][wa] = (ACC && acc) ? sat32(mem_m[wb_m][wa], wd) : wd;
        end
        if (wc) begin
            if (wrdy) begin full_m[wb_m] = 1; wb_m ^= 1; end
            else err_m = 1;
        end
        if (rr) begin
            if (ravl) begin full_m[rb_m] = 0; rb_m ^= 1; end
            else err_m = 1;
        end
        #1;
        check_outputs();
        idle();
    endtask

    // Asserts reset between edges, checks the asynchronous effect, then the first edge under reset.
    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        full_m = '{0, 0}; wb_m = 0; rb_m = 0; err_m = 0; vld_m = 0; data_m = 0;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b1;
        idle();
        do_reset();

        // Fill bank 0 with addr*3, commit, read it all back.
        for (int a = 0; a < DEPTH; a++) cyc(1, a, a * 3, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        for (int a = 0; a < DEPTH; a++) begin
            cyc(0, 0, 0, 0, 0, 1, a, 0);
            chk("seq_read_data", rd_data, 64'(a * 3));
            chk("seq_fill", 64'(fill_level), 64'd1);
        end

        // Fill and commit bank 1, then over-commit.
        for (int a = 0; a < DEPTH; a++) cyc(1, a, $urandom, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("both_full_fill", 64'(fill_level), 64'd2);
        chk("both_full_wr_ready", 64'(wr_ready), 64'd0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("overcommit_err", 64'(err), 64'd1);
        chk("overcommit_fill", 64'(fill_level), 64'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("release_wr_ready", 64'(wr_ready), 64'd1);
        cyc(0, 0, 0, 0, 0, 1, 7, 0);
        chk("release_reads_bank1", rd_data, mem_m[1][7]);

        // Commit and release together with one bank full.
        do_reset();
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 1);
        chk("swap_fill", 64'(fill_level), 64'd1);
        chk("swap_wr_ready", 64'(wr_ready), 64'd1);
        cyc(0, 0, 0, 0, 0, 1, 3, 0);
        chk("swap_reads_bank1", rd_data, mem_m[1][3]);
        chk("swap_err_clear", 64'(err), 64'd0);

        // Out-of-range write and read; the dropped write must not alias onto address 0.
        cyc(1, 64, 12345, 0, 0, 1, 70, 0);
        chk("oob_rd_valid", 64'(rd_valid), 64'd1);
        chk("oob_rd_data", rd_data, 64'd0);
        chk("oob_err", 64'(err), 64'd1);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("oob_no_alias", rd_data, 64'd0);

        // Saturating accumulate and back-to-back accumulate (plain overwrite when disabled).
        do_reset();
        cyc(1, 0, 32'sh7ffffff0, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'sh00000100, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 5, 1, 0, 0, 0, 0);
        cyc(1, 1, 5, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("acc_saturate", rd_data, ACC ? 64'h7fffffff : 64'h100);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        chk("acc_back_to_back", rd_data, ACC ? 64'd10 : 64'd5);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // Random traffic against the model, with periodic resets to re-arm the sticky error.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int wa, ra;
            wa = ($urandom_range(0, 15) == 0) ? 64 + $urandom_range(0, 5) : $urandom_range(0, 63);
            ra = ($urandom_range(0, 15) == 0) ? 64 + $urandom_range(0, 5) : $urandom_range(0, 63);
            cyc($urandom_range(0, 9) < 6, wa, $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), ra, $urandom_range(0, 7) == 0);
            if (i % 100 == 99) begin
                cyc(0, 0, 0, 0, 0, 0, 0, 0);
                do_reset();
            end
        end

        // Reset with both banks full and a read in flight.
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("pre_reset_fill", 64'(fill_level), 64'd2);
        cyc(0, 0, 0, 0, 0, 1, 5, 0);
        chk("pre_reset_rd_valid", 64'(rd_valid), 64'd1);
        rd_en = 1; rd_addr = 6;
        do_reset();
        chk("post_reset_fill", 64'(fill_level), 64'd0);
        chk("post_reset_rd_valid", 64'(rd_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
